// File: rtl/add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package add_ctrl_pkg;

    // Width of one adder slice.
    localparam int unsigned NIB_W = 4;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Width of the nibble index counter: clog2(nibbles), never below 1.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry adder shared by the serial controller.
module rca
    import add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             c_in,
    output logic [NIB_W-1:0] sum,
    output logic             c_out
);

    logic [NIB_W:0] carry;

    // Bit-by-bit ripple of the carry through the slice.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[NIB_W];
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-word add/subtract controller: feeds one nibble per clock through a
// shared 4-bit rca, LS nibble first, chaining the carry through a register.
module serial_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] result,
    output logic                     carry_out,
    output logic                     overflow
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [W-1:0]       opa;
    logic [W-1:0]       opb;
    logic               cy;
    logic [IDX_W-1:0]   idx;
    logic               a_msb;
    logic               b_msb;

    logic [W-1:0]       b_eff;
    logic [NIB_W-1:0]   sum4;
    logic               c4;
    logic [W+NIB_W-1:0] shifted;

    rca u_rca (
        .a     (opa[NIB_W-1:0]),
        .b     (opb[NIB_W-1:0]),
        .c_in  (cy),
        .sum   (sum4),
        .c_out (c4)
    );

    // Operand B as presented to the adder (inverted for subtract) and the
    // result shift path; concatenating first keeps the single-nibble case legal.
    always_comb begin
        b_eff   = sub ? ~b : b;
        shifted = {sum4, result};
    end

    // Controller FSM with shift registers, carry chain and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            cy        <= 1'b0;
            idx       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        opa   <= a;
                        opb   <= b_eff;
                        cy    <= sub;
                        idx   <= '0;
                        a_msb <= a[W-1];
                        b_msb <= b_eff[W-1];
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    result <= shifted[W+NIB_W-1:NIB_W];
                    opa    <= opa >> NIB_W;
                    opb    <= opb >> NIB_W;
                    cy     <= c4;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        carry_out <= c4;
                        overflow  <= (a_msb == b_msb) && (sum4[NIB_W-1] != a_msb);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with NIBBLES=4.
module tb_serial_add_ctrl;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 16;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    serial_add_ctrl #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference from integer math, independent of nibble sequencing.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int   ux = int'(x);
        int   uy = int'(y);
        int   sx = int'($signed(x));
        int   sy = int'($signed(y));
        int   ur = s ? (ux - uy) : (ux + uy);
        int   sr = s ? (sx - sy) : (sx + sy);
        e.r = ur[W-1:0];
        e.c = s ? (ux >= uy) : (ux + uy > 32'hFFFF);
        e.v = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    // Scoreboard consumer: compare every done cycle against the oldest entry.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {16'd0, result}, {16'd0, e.r});
                check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
                check("overflow", {31'd0, overflow}, {31'd0, e.v});
            end
        end
        prev_done = done;
    end

    // Count edges after the start edge until done shows; bounded.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 20) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input exp_t e);
        int cnt;
        @(negedge clk);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(cnt);
        check("latency", cnt, NIB);
        @(posedge clk);
        #1;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("result_hold", {16'd0, result}, {16'd0, e.r});
    endtask

    initial begin
        int   cnt;
        exp_t e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic s;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived expectations.
        run_op(16'h1234, 16'h4321, 1'b0, '{r: 16'h5555, c: 1'b0, v: 1'b0});
        run_op(16'hFFFF, 16'h0001, 1'b0, '{r: 16'h0000, c: 1'b1, v: 1'b0});
        run_op(16'h7FFF, 16'h0001, 1'b0, '{r: 16'h8000, c: 1'b0, v: 1'b1});
        run_op(16'h0005, 16'h0007, 1'b1, '{r: 16'hFFFE, c: 1'b0, v: 1'b0});
        run_op(16'h8000, 16'h0001, 1'b1, '{r: 16'h7FFF, c: 1'b1, v: 1'b1});

        // Start held high: new operands during RUN are ignored, then accepted
        // in the IDLE cycle following done.
        @(negedge clk);
        a     = 16'h1111;
        b     = 16'h2222;
        sub   = 1'b0;
        start = 1'b1;
        sb.push_back('{r: 16'h3333, c: 1'b0, v: 1'b0});
        sb.push_back('{r: 16'hFFFF, c: 1'b0, v: 1'b0});
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        b = 16'h5555;
        wait_done(cnt);
        check("b2b_latency1", cnt, NIB);
        @(posedge clk);
        #1;
        check("b2b_gap_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(cnt);
        check("b2b_latency2", cnt, NIB);
        @(posedge clk);
        #1;

        // Reset asserted at the second RUN edge abandons the operation.
        @(negedge clk);
        a     = 16'h1234;
        b     = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_done", {31'd0, done}, 32'd0);
        check("midrun_rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, '{r: 16'h0100, c: 1'b0, v: 1'b0});

        // Random operations against the integer model.
        for (int i = 0; i < 8; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            e = model(x, y, s);
            run_op(x, y, s, e);
        end

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
